// File: rtl/ol_argmax_ctrl_pkg.sv
// Shared constants and types for the output-layer argmax sequencer.
package ol_argmax_ctrl_pkg;

    localparam int FP_W   = 32;
    localparam int N_OUT  = 10;
    localparam int IDX_W  = 4;
    localparam int LIDX_W = $clog2(N_OUT);

    typedef logic [FP_W-1:0] fp32_t;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/ol_argmax_ctrl_if.sv
// Neuron input stream and class-result handshake bundled as one interface.
interface ol_argmax_ctrl_if;
    import ol_argmax_ctrl_pkg::*;

    logic             in_valid;
    fp32_t            in_data;
    logic             in_ready;
    logic             res_valid;
    logic [IDX_W-1:0] res_data;
    logic             res_ready;

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data
    );

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data
    );

endinterface

// File: rtl/ol_argmax_ctrl_load_buf.sv
// Write-indexed neuron buffer; all entries are exposed flat to the findmax datapath.
module ol_load_buf
    import ol_argmax_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic [LIDX_W-1:0]       widx_i,
    input  fp32_t                   wdata_i,
    output logic [N_OUT*FP_W-1:0]   fm_in_o
);

    fp32_t buf_q [N_OUT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_OUT; i++) begin
                buf_q[i] <= '0;
            end
        end else if (we_i) begin
            buf_q[widx_i] <= wdata_i;
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        assign fm_in_o[i*FP_W +: FP_W] = buf_q[i];
    end

endmodule

// File: rtl/ol_argmax_ctrl.sv
// Collects one frame of output neurons, waits for findmax to settle, and hands out the class index.
//   state  | meaning
//   S_LOAD | accepting neuron words into the buffer
//   S_WAIT | buffer frozen, counting down the findmax settle time
//   S_OUT  | class index held on res_* until consumed
module ol_argmax_ctrl
    import ol_argmax_ctrl_pkg::*;
#(
    parameter int FM_LATENCY = 8,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    ol_argmax_ctrl_if.slave         bus,
    input  logic                    clear,
    output logic [N_OUT*FP_W-1:0]   fm_in,
    input  logic [IDX_W-1:0]        fm_result,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic                    busy
);

    localparam int WCNT_W = (FM_LATENCY > 1) ? $clog2(FM_LATENCY) : 1;

    state_e              state_q, state_d;
    logic [LIDX_W-1:0]   idx_q, idx_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                res_valid_q, res_valid_d;
    logic [IDX_W-1:0]    res_data_q, res_data_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                buf_we;

    ol_load_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (buf_we),
        .widx_i  (idx_q),
        .wdata_i (bus.in_data),
        .fm_in_o (fm_in)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            idx_q       <= '0;
            wcnt_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        frame_cnt_d = frame_cnt_q;
        buf_we      = 1'b0;

        // clear wins over any beat or handshake in the same cycle
        if (clear) begin
            state_d     = S_LOAD;
            idx_d       = '0;
            wcnt_d      = '0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        buf_we = 1'b1;
                        if (idx_q == LIDX_W'(N_OUT-1)) begin
                            idx_d   = '0;
                            wcnt_d  = WCNT_W'(FM_LATENCY-1);
                            state_d = S_WAIT;
                        end else begin
                            idx_d = idx_q + LIDX_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == '0) begin
                        res_data_d  = fm_result;
                        res_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else begin
                        wcnt_d = wcnt_q - WCNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (res_valid_q && bus.res_ready) begin
                        res_valid_d = 1'b0;
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        state_d     = S_LOAD;
                    end
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign frame_cnt     = frame_cnt_q;
    assign busy          = !((state_q == S_LOAD) && (idx_q == '0));

endmodule

// File: tb/tb_ol_argmax_ctrl.sv
// Directed and randomized checks of the argmax sequencer against a frame-level reference model.
module tb_ol_argmax_ctrl;
    import ol_argmax_ctrl_pkg::*;

    localparam int L   = 8;
    localparam int T   = 10;
    localparam int BIG = N_OUT*FP_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic [BIG-1:0]    fm_in;
    logic [IDX_W-1:0]  fm_result;
    logic [15:0]       frame_cnt;
    logic              busy;

    ol_argmax_ctrl_if bus ();

    ol_argmax_ctrl #(.FM_LATENCY(L), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clear     (clear),
        .fm_in     (fm_in),
        .fm_result (fm_result),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    always #(T/2) clk = ~clk;

    int    n_chk = 0;
    int    n_err = 0;
    fp32_t exp_buf [N_OUT];
    int    exp_cnt = 0;

    // order-preserving key for IEEE-754 compare; earliest index wins ties
    function automatic logic [31:0] fkey(input fp32_t x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic logic [IDX_W-1:0] ref_argmax(input fp32_t v [N_OUT]);
        int best = 0;
        for (int i = 1; i < N_OUT; i++)
            if (fkey(v[i]) > fkey(v[best])) best = i;
        return IDX_W'(best);
    endfunction

    // stand-in findmax datapath: output is garbage until fm_in has been stable FM_LATENCY cycles
    time last_change = 0;
    always @(fm_in) last_change = $time;

    always @(negedge clk) begin
        fp32_t a [N_OUT];
        for (int i = 0; i < N_OUT; i++) a[i] = fm_in[i*FP_W +: FP_W];
        if (($time - last_change) >= time'(L*T - T/2)) fm_result = ref_argmax(a);
        else fm_result = 4'hF;
    end

    function automatic logic [BIG-1:0] pack_buf();
        logic [BIG-1:0] p;
        for (int i = 0; i < N_OUT; i++) p[i*FP_W +: FP_W] = exp_buf[i];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [BIG-1:0] obs, input logic [BIG-1:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // sends beats 0..count-1, optionally with an idle cycle between beats; ends at the negedge after the last beat
    task automatic send_beats(input fp32_t vals [N_OUT], input int count, input bit gap);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            if (gap && i > 0) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            chk("in_ready_load", BIG'(bus.in_ready), BIG'(1));
            bus.in_valid = 1'b1;
            bus.in_data  = vals[i];
            exp_buf[i]   = vals[i];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic get_result(input logic [IDX_W-1:0] exp_idx, input int bp, input string tag);
        int n = 0;
        logic [IDX_W-1:0] held;
        while (!bus.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, BIG'(n + 1), BIG'(L + 1));
        chk({tag, "_res_data"}, BIG'(bus.res_data), BIG'(exp_idx));
        chk({tag, "_fm_in"}, fm_in, pack_buf());
        held = bus.res_data;
        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            chk({tag, "_hold"}, BIG'({bus.res_valid, bus.in_ready, bus.res_data}),
                BIG'({1'b1, 1'b0, held}));
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        exp_cnt++;
        chk({tag, "_after_hs"}, BIG'({frame_cnt, bus.res_valid, bus.in_ready}),
            BIG'({exp_cnt[15:0], 1'b0, 1'b1}));
    endtask

    task automatic watch_no_result(input int cycles, input string tag);
        logic seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        chk(tag, BIG'(seen), BIG'(0));
    endtask

    initial begin
        fp32_t asc [N_OUT];
        fp32_t v   [N_OUT];
        logic [IDX_W-1:0] e;

        asc = '{32'h41200000, 32'h41A00000, 32'h41F00000, 32'h42200000, 32'h42480000,
                32'h42700000, 32'h428C0000, 32'h42A00000, 32'h42B40000, 32'h42C80000};

        rst = 1'b1; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ready = 1'b0;
        for (int i = 0; i < N_OUT; i++) exp_buf[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_outs", BIG'({bus.in_ready, bus.res_valid, bus.res_data, frame_cnt, busy}),
            BIG'({1'b1, 1'b0, 4'd0, 16'd0, 1'b0}));
        chk("reset_fm_in", fm_in, '0);

        // ascending frame, back-to-back
        send_beats(asc, N_OUT, 1'b0);
        get_result(ref_argmax(asc), 0, "asc");

        // backpressure on a random frame
        for (int i = 0; i < N_OUT; i++) v[i] = $urandom;
        send_beats(v, N_OUT, 1'b0);
        get_result(ref_argmax(v), 20, "bp");

        // gapped input, same data as ascending frame
        send_beats(asc, N_OUT, 1'b1);
        get_result(ref_argmax(asc), 0, "gap");

        // max rotated k = 9..0
        for (int k = N_OUT-1; k >= 0; k--) begin
            for (int i = 0; i < N_OUT; i++) v[i] = $urandom_range(0, 32'h42C7FFFF);
            v[k] = 32'h42C80000;
            send_beats(v, N_OUT, 1'b0);
            get_result(IDX_W'(k), 0, "rot");
        end
        chk("rot_cnt", BIG'(frame_cnt), BIG'(exp_cnt));

        // clear after 6 beats, with a beat presented alongside clear
        for (int i = 0; i < N_OUT; i++) v[i] = $urandom_range(0, 32'h3FFFFFFF);
        send_beats(v, 6, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h7F7FFFFF;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clear_state", BIG'({busy, bus.in_ready, bus.res_valid}), BIG'({1'b0, 1'b1, 1'b0}));
        chk("clear_buf", fm_in, pack_buf());
        watch_no_result(L + 4, "clear_no_res");
        for (int i = 0; i < N_OUT; i++) v[i] = $urandom_range(0, 32'h42C7FFFF);
        v[2] = 32'h42C80000;
        send_beats(v, N_OUT, 1'b0);
        get_result(4'd2, 0, "clr_frame");

        // randomized frames with random gaps and backpressure, including negatives
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N_OUT; i++) v[i] = $urandom;
            e = ref_argmax(v);
            send_beats(v, N_OUT, 1'($urandom_range(0, 1)));
            get_result(e, $urandom_range(0, 3), "rand");
        end

        // reset during WAIT
        for (int i = 0; i < N_OUT; i++) v[i] = $urandom;
        send_beats(v, N_OUT, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < N_OUT; i++) exp_buf[i] = '0;
        chk("rst_wait_outs", BIG'({bus.in_ready, bus.res_valid, frame_cnt, busy}),
            BIG'({1'b1, 1'b0, 16'd0, 1'b0}));
        chk("rst_wait_fm_in", fm_in, '0);
        watch_no_result(L + 4, "rst_no_res");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
